// File: rtl/bcd_display_driver.sv
// bcd_display_driver: sequential double-dabble binary-to-BCD converter driving
// registered active-low 7-segment digits with blanking, sign and overflow.
module bcd_display_driver #(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter bit SIGNED   = 1'b1,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [WIDTH-1:0]    in_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [7*DIGITS-1:0] seg_o,
  output logic                negative_o,
  output logic                overflow_o
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [BW-1:0]       bcd_q, bcd_d, adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d, sign_q, sign_d;
  logic [7*DIGITS-1:0] seg_q, seg_d, img;
  logic                neg_q, neg_d, ovo_q, ovo_d, done_q, done_d;

  function automatic logic [6:0] enc(logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k +: 4] = bcd_q[4*k +: 4] >= 4'd5 ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
  end

  // Walk from the top digit down; blanking stops at the first nonzero digit.
  always_comb begin
    logic lead;
    lead = 1'b1;
    img = '1;
    for (int k = DIGITS-1; k >= 0; k--) begin
      img[7*k +: 7] = ovf_q ? 7'h3F :
                      (BLANK_LZ && lead && k != 0 && bcd_q[4*k +: 4] == 4'd0) ? 7'h7F :
                      enc(bcd_q[4*k +: 4]);
      lead = lead && bcd_q[4*k +: 4] == 4'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sign_d  = sign_q;
    seg_d   = seg_q;
    neg_d   = neg_q;
    ovo_d   = ovo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (load_i) begin
        sign_d  = SIGNED && in_i[WIDTH-1];
        sh_d    = (SIGNED && in_i[WIDTH-1]) ? -in_i : in_i;
        bcd_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = CW'(WIDTH);
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, sh_d} = {adj[BW-2:0], sh_q, 1'b0};
        ovf_d   = ovf_q | adj[BW-1];
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? LATCH : SHIFT;
      end
      LATCH: begin
        seg_d   = img;
        neg_d   = sign_q;
        ovo_d   = ovf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
      seg_q   <= '1;
      neg_q   <= 1'b0;
      ovo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sign_q  <= sign_d;
      seg_q   <= seg_d;
      neg_q   <= neg_d;
      ovo_q   <= ovo_d;
      done_q  <= done_d;
    end

  assign busy_o     = state_q != IDLE;
  assign done_o     = done_q;
  assign seg_o      = seg_q;
  assign negative_o = neg_q;
  assign overflow_o = ovo_q;
endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: three 8-bit configurations share one stimulus stream;
// expected displays come from a decimal-arithmetic model and hand constants.
module tb_bcd_display_driver;
  logic clk = 1'b0, rst_n = 1'b1, load = 1'b0;
  logic [7:0] din = '0;
  logic busy_a, done_a, neg_a, ovf_a, busy_b, done_b, neg_b, ovf_b, busy_c, done_c, neg_c, ovf_c;
  logic [20:0] seg_a, seg_b;
  logic [13:0] seg_c;
  int total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_display_driver #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1), .BLANK_LZ(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .load_i(load), .in_i(din), .busy_o(busy_a), .done_o(done_a),
    .seg_o(seg_a), .negative_o(neg_a), .overflow_o(ovf_a));
  bcd_display_driver #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1), .BLANK_LZ(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .load_i(load), .in_i(din), .busy_o(busy_b), .done_o(done_b),
    .seg_o(seg_b), .negative_o(neg_b), .overflow_o(ovf_b));
  bcd_display_driver #(.WIDTH(8), .DIGITS(2), .SIGNED(1'b0), .BLANK_LZ(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .load_i(load), .in_i(din), .busy_o(busy_c), .done_o(done_c),
    .seg_o(seg_c), .negative_o(neg_c), .overflow_o(ovf_c));

  typedef struct {
    logic [7:0]  v;
    logic [20:0] sa;
    logic        na;
    logic        oa;
    logic [20:0] sb;
    logic [13:0] sc;
    logic        oc;
  } rec_t;
  typedef struct {
    rec_t r;
    int   t0;
  } qe_t;

  qe_t  q[$];
  rec_t tbl[12];

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] enc(int d);
    logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return lut[d];
  endfunction

  function automatic logic [20:0] img(int m, int nd, bit bl);
    logic [20:0] r;
    int p, lim;
    r = '1;
    lim = 1;
    for (int k = 0; k < nd; k++) lim *= 10;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      r[7*k +: 7] = m >= lim ? 7'h3F : (bl && k > 0 && m < p) ? 7'h7F : enc((m / p) % 10);
      p *= 10;
    end
    return r;
  endfunction

  function automatic rec_t mk(logic [7:0] v);
    rec_t r;
    int m;
    m = v[7] ? 256 - int'(v) : int'(v);
    r.v  = v;
    r.sa = img(m, 3, 1'b1);
    r.na = v[7];
    r.oa = m >= 1000;
    r.sb = img(m, 3, 1'b0);
    r.sc = img(int'(v), 2, 1'b1) & 21'h3FFF;
    r.oc = v >= 8'd100;
    return r;
  endfunction

  always @(negedge clk) if (rst_n) begin
    chk("done_busy_a", {31'd0, done_a & busy_a}, 0);
    if (done_a) begin
      if (q.size() == 0) chk("extra_done", 1, 0);
      else begin
        qe_t e;
        e = q.pop_front();
        chk("latency", cyc - e.t0, 9);
        chk("seg_a", seg_a, e.r.sa);
        chk("neg_a", neg_a, e.r.na);
        chk("ovf_a", ovf_a, e.r.oa);
        chk("done_b", done_b, 1);
        chk("seg_b", seg_b, e.r.sb);
        chk("neg_b", neg_b, e.r.na);
        chk("done_c", done_c, 1);
        chk("seg_c", seg_c, e.r.sc);
        chk("neg_c", neg_c, 0);
        chk("ovf_c", ovf_c, e.r.oc);
      end
    end
  end

  // Call positioned at a negedge; returns #1 after the load edge.
  task automatic drive(rec_t r, bit push);
    load = 1'b1;
    din  = r.v;
    @(posedge clk);
    #1;
    if (push) q.push_back('{r, cyc});
    load = 1'b0;
    din  = 8'($urandom);
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_timeout", {31'd0, got}, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic chk_reset(string n);
    chk({n, "_seg_a"}, seg_a, 21'h1FFFFF);
    chk({n, "_seg_c"}, seg_c, 14'h3FFF);
    chk({n, "_busy"}, {busy_a, busy_b, busy_c}, 0);
    chk({n, "_done"}, {done_a, done_b, done_c}, 0);
    chk({n, "_flags"}, {neg_a, ovf_a, neg_c, ovf_c}, 0);
  endtask

  initial begin
    tbl[0] = '{8'd123, {7'h79, 7'h24, 7'h30}, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30}, {7'h3F, 7'h3F}, 1'b1};
    tbl[1] = '{8'h80,  {7'h79, 7'h24, 7'h00}, 1'b1, 1'b0, {7'h79, 7'h24, 7'h00}, {7'h3F, 7'h3F}, 1'b1};
    tbl[2] = '{8'hFF,  {7'h7F, 7'h7F, 7'h79}, 1'b1, 1'b0, {7'h40, 7'h40, 7'h79}, {7'h3F, 7'h3F}, 1'b1};
    tbl[3] = '{8'd0,   {7'h7F, 7'h7F, 7'h40}, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40}, {7'h7F, 7'h40}, 1'b0};
    tbl[4] = '{8'd99,  {7'h7F, 7'h10, 7'h10}, 1'b0, 1'b0, {7'h40, 7'h10, 7'h10}, {7'h10, 7'h10}, 1'b0};
    tbl[5] = '{8'd100, {7'h79, 7'h40, 7'h40}, 1'b0, 1'b0, {7'h79, 7'h40, 7'h40}, {7'h3F, 7'h3F}, 1'b1};
    tbl[6] = '{8'd5,   {7'h7F, 7'h7F, 7'h12}, 1'b0, 1'b0, {7'h40, 7'h40, 7'h12}, {7'h7F, 7'h12}, 1'b0};
    for (int i = 7; i < 12; i++) tbl[i] = mk(8'($urandom));
    #1 rst_n = 1'b0;
    #3 chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i], 1'b1);
      drain();
    end
    // load during busy is dropped; load in the done cycle is taken
    @(negedge clk);
    drive(mk(8'd42), 1'b1);
    repeat (2) @(negedge clk);
    load = 1'b1;
    din  = 8'd7;
    @(posedge clk);
    #1 load = 1'b0;
    wait_done();
    drive(mk(8'd7), 1'b1);
    drain();
    // asynchronous reset in the middle of a conversion
    @(negedge clk);
    drive(mk(8'd123), 1'b1);
    drain();
    chk("hold_seg_a", seg_a, {7'h79, 7'h24, 7'h30});
    drive(mk(8'd55), 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset("midshift");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(mk(8'hFF), 1'b1);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Parametrised successor to the team's 8-bit binary-to-7-segment output path. Converts a WIDTH-bit signed or unsigned value into DIGITS decimal digits, one shift-add-3 (double-dabble) step per clock. Drives DIGITS registered 7-segment patterns with leading-zero blanking, a separate sign output and an overflow indication. Sits between the processor's output register and the board displays, and replaces the combinational converter with a load/busy/done handshake.

## Interface
- WIDTH, 16: input data width in bits, ≥ 2.
- DIGITS, 5: number of decimal digits and 7-segment outputs, ≥ 1.
- SIGNED, 1: 1 = input is two's complement; 0 = input is unsigned.
- BLANK_LZ, 1: 1 = blank leading zero digits; 0 = show all digits.
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  start conversion of `in`; honoured only when busy=0.
- in  in  WIDTH  value to display; sampled on the accepted load edge.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse: seg, negative and overflow updated.
- seg  out  7*DIGITS  digit k on seg[7k+6:7k], k=0 is units. Bit order {g,f,e,d,c,b,a}, active-low.
- negative  out  1  displayed value is negative; always 0 when SIGNED=0.
- overflow  out  1  magnitude ≥ 10^DIGITS.

## Operation
- FSM states are IDLE, SHIFT and LATCH. Reset state is IDLE.
- IDLE: on load=1, capture the magnitude into a WIDTH-bit shift register, capture the sign, clear the BCD register and overflow bit, load the step counter with WIDTH, and go to SHIFT.
- Magnitude: if SIGNED=1 and in[WIDTH-1]=1, magnitude = (~in)+1, taken as WIDTH-bit unsigned. The most negative value therefore yields 2^(WIDTH-1). Otherwise magnitude = in.
- SHIFT, each cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift {BCD, shift register} left by 1.
  - A 1 shifted out of the top nibble sets a sticky overflow bit.
  - Decrement the counter. When it reaches 0, go to LATCH.
- LATCH: update all outputs, pulse done, go to IDLE.
- Digit encoding, active-low: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10. Blank=0x7F. Dash=0x3F.
- Leading-zero blanking (BLANK_LZ=1): every zero digit above the most significant nonzero digit shows blank. Digit 0 is never blanked, so a value of 0 shows "0".
- Overflow: every digit shows dash and overflow=1. negative still reflects the sign.
- negative=1 only if the input was negative and the magnitude is nonzero.
- load while busy=1 is ignored. It does not queue, and in-flight data is unaffected.
- Outputs hold their last values until the next LATCH.

## Timing
- Reset (asynchronous, immediate): busy=0, done=0, seg all 0x7F (blank), negative=0, overflow=0. State returns to IDLE.
- Reset during SHIFT aborts the conversion; outputs take the reset values above.
- Load accepted at edge E0. busy=1 after E0.
- Edges E1..E_WIDTH perform the shifts.
- Edge E_WIDTH+1 updates seg, negative and overflow; after it, done=1 and busy=0 for one cycle.
- Latency from load edge to valid outputs: WIDTH+1 cycles.
- A load asserted in the cycle where done=1 is accepted (busy=0), so back-to-back throughput is one conversion per WIDTH+2 cycles.
- done is low in every cycle except the one after LATCH. done and busy are never high together.
- in may change freely after the load edge.

## Test plan
- WIDTH=8, DIGITS=3, SIGNED=1: load in=8'd123.
  - done pulses exactly 9 cycles after the load edge.
  - seg[20:14]=0x79, seg[13:7]=0x24, seg[6:0]=0x30; negative=0, overflow=0.
- Same configuration: load in=8'h80 (-128).
  - Digits read 0x79, 0x24, 0x00 ("128"); negative=1.
  - Then load 8'hFF: shows 0x7F, 0x7F, 0x79 ("1") with negative=1.
- Same configuration: load in=0.
  - seg = 0x7F, 0x7F, 0x40; negative=0.
  - With BLANK_LZ=0: seg = 0x40, 0x40, 0x40.
- WIDTH=8, DIGITS=2, SIGNED=0: load 8'd99.
  - seg = 0x10, 0x10; overflow=0.
  - Then load 8'd100: both digits 0x3F, overflow=1.
- Pulse load with 8'd7 during busy (cycle 3 of a conversion of 8'd42): ignored; result is "42", and only one done pulse occurs.
  - A load with 8'd7 in the done cycle is accepted and shows "7" 9 cycles later.
- Assert reset_n=0 mid-SHIFT after showing "123": outputs go blank immediately (asynchronous), busy=0.
  - After release, a new load converts correctly.
